// File: rtl/nibble_loader.sv
// nibble_loader: assembles a 32-bit word from eight hex digits entered one at
// a time, exposing the working word and digit pointer for live display.
// Optional feature: define NIBBLE_LOADER_SHIFT_EN for calculator-style entry,
// where each new digit shifts the word left and lands in bits [3:0].
module nibble_loader #(
  parameter int NDIG = 8,
  parameter int PW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        nib_in,
  input  logic              nib_valid,
  input  logic              clear,
  input  logic              commit,
  output logic [4*NDIG-1:0] work,
  output logic [4*NDIG-1:0] D_out,
  output logic [PW-1:0]     ptr,
  output logic              full,
  output logic              ovf,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [PW-1:0] PTR_LAST = PW'(NDIG - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [1:0]        state_q, state_d;
  logic [4*NDIG-1:0] work_q, work_d;
  logic [4*NDIG-1:0] d_out_q, d_out_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  // Next-state logic: clear beats commit, commit beats a nibble strobe
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    d_out_d = d_out_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      work_d  = '0;
      ptr_d   = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (commit && (state_q != ST_IDLE)) begin
      d_out_d = work_q;
      done_d  = 1'b1;
      state_d = ST_IDLE;
      work_d  = '0;
      ptr_d   = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (nib_valid) begin
      if (state_q == ST_FULL) begin
        ovf_d = 1'b1;
      end else begin
`ifdef NIBBLE_LOADER_SHIFT_EN
        work_d = {work_q[4*NDIG-5:0], nib_in};
`else
        work_d[4*ptr_q +: 4] = nib_in;
`endif
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = ST_FULL;
          full_d  = 1'b1;
        end else begin
          state_d = ST_ENTRY;
        end
      end
    end
  end

  // State registers with synchronous reset overriding every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      d_out_q <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      d_out_q <= d_out_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign work  = work_q;
  assign D_out = d_out_q;
  assign ptr   = ptr_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign done  = done_q;

endmodule

// File: tb/tb_nibble_loader.sv
// Testbench for nibble_loader: directed scenarios followed by random strobes,
// all checked against a digit-queue reference model.
module tb_nibble_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  nib_in = 4'd0;
  logic        nib_valid = 1'b0;
  logic        clear = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] work;
  logic [31:0] D_out;
  logic [2:0]  ptr;
  logic        full;
  logic        ovf;
  logic        done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: the digits entered so far, oldest first
  logic [3:0]  m_digits[$];
  logic [31:0] m_dout = 32'd0;
  logic        m_ovf  = 1'b0;
  logic        m_done = 1'b0;

  nibble_loader #(.NDIG(8), .PW(3)) dut (
    .clk(clk), .reset(reset), .nib_in(nib_in), .nib_valid(nib_valid),
    .clear(clear), .commit(commit), .work(work), .D_out(D_out),
    .ptr(ptr), .full(full), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_work();
    logic [31:0] w = 32'd0;
`ifdef NIBBLE_LOADER_SHIFT_EN
    foreach (m_digits[i]) w = (w << 4) | 32'(m_digits[i]);
`else
    foreach (m_digits[i]) w = w | (32'(m_digits[i]) << (4 * i));
`endif
    return w;
  endfunction

  task automatic model_step(input logic r, input logic cl, input logic cm,
                            input logic nv, input logic [3:0] n);
    m_done = 1'b0;
    if (r) begin
      m_digits.delete();
      m_dout = 32'd0;
      m_ovf  = 1'b0;
    end else if (cl) begin
      m_digits.delete();
      m_ovf = 1'b0;
    end else if (cm && m_digits.size() > 0) begin
      m_dout = model_work();
      m_done = 1'b1;
      m_digits.delete();
      m_ovf = 1'b0;
    end else if (nv) begin
      if (m_digits.size() == 8) m_ovf = 1'b1;
      else m_digits.push_back(n);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic checkOutput();
    chk("work",  work,         model_work());
    chk("D_out", D_out,        m_dout);
    chk("ptr",   32'(ptr),     32'(m_digits.size() % 8));
    chk("full",  32'(full),    32'(m_digits.size() == 8));
    chk("ovf",   32'(ovf),     32'(m_ovf));
    chk("done",  32'(done),    32'(m_done));
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare
  task automatic applyStimulus(input logic r, input logic cl, input logic cm,
                               input logic nv, input logic [3:0] n);
    reset = r; clear = cl; commit = cm; nib_valid = nv; nib_in = n;
    @(posedge clk);
    #1;
    model_step(r, cl, cm, nv, n);
    reset = 1'b0; clear = 1'b0; commit = 1'b0; nib_valid = 1'b0;
    checkOutput();
  endtask

  initial begin
    #2;
    // Reset state
    applyStimulus(1, 0, 0, 0, 4'd0);

    // Full word 1..8 then commit
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 1, 4'(i));
`ifdef NIBBLE_LOADER_SHIFT_EN
    chk("full_word_const", work, 32'h12345678);
`else
    chk("full_word_const", work, 32'h87654321);
`endif
    applyStimulus(0, 0, 1, 0, 4'd0);
`ifndef NIBBLE_LOADER_SHIFT_EN
    chk("commit_const", D_out, 32'h87654321);
`endif
    chk("commit_done", 32'(done), 32'd1);
    applyStimulus(0, 0, 0, 0, 4'd0);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Partial entry and a second ignored commit
    applyStimulus(0, 0, 0, 1, 4'hA);
    applyStimulus(0, 0, 0, 1, 4'hB);
    applyStimulus(0, 0, 1, 0, 4'd0);
`ifdef NIBBLE_LOADER_SHIFT_EN
    chk("partial_const", D_out, 32'h000000AB);
`else
    chk("partial_const", D_out, 32'h000000BA);
`endif
    applyStimulus(0, 0, 1, 0, 4'd0);
    chk("second_commit_no_done", 32'(done), 32'd0);

    // Overflow then clear
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 4'(i + 3));
    applyStimulus(0, 0, 0, 1, 4'hF);
    chk("ovf_set", 32'(ovf), 32'd1);
    applyStimulus(0, 1, 0, 0, 4'd0);

    // Commit wins over a same-cycle nibble
    applyStimulus(0, 0, 0, 1, 4'd3);
    applyStimulus(0, 0, 1, 1, 4'd9);
    chk("commit_beats_nib", D_out, 32'h00000003);

    // Clear wins over a same-cycle commit
    applyStimulus(0, 0, 0, 1, 4'd5);
    applyStimulus(0, 1, 1, 0, 4'd0);
    chk("clear_beats_commit", 32'(done), 32'd0);

    // Reset mid-entry
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 4'(i + 1));
    applyStimulus(1, 0, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 1, 4'd6);
    chk("after_reset_work", work, 32'h00000006);

    // Shift-mode calculator example
`ifdef NIBBLE_LOADER_SHIFT_EN
    applyStimulus(0, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 1, 4'(i));
    applyStimulus(0, 0, 1, 0, 4'd0);
    chk("shift_123", D_out, 32'h00000123);
`endif

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic r, cl, cm, nv;
      r  = ($urandom_range(0, 99) < 2);
      cl = ($urandom_range(0, 99) < 4);
      cm = ($urandom_range(0, 99) < 10);
      nv = ($urandom_range(0, 99) < 60);
      if (cm && m_digits.size() == 0) nv = 1'b0;
      applyStimulus(r, cl, cm, nv, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
